// File: rtl/regfile_write_ctrl_pkg.sv
// ============================================================================
// Module : regfile_ctrl_pkg
// Brief  : Shared types, sizes and helpers for the register-file write control
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_ctrl_pkg;

    localparam int NUM_REGS = 4;
    localparam int RADDR_W  = 2;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    function automatic logic [NUM_REGS-1:0] onehot4(input logic [RADDR_W-1:0] addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_write_ctrl_if.sv
// ============================================================================
// Module : regfile_write_ctrl_if
// Brief  : Requester bus, clear control and register-file write strobes
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_write_ctrl_if #(
    parameter int NREQ = 3,
    parameter int DW   = 8
);
    import regfile_ctrl_pkg::*;

    logic [NREQ-1:0]         req_valid;
    logic [RADDR_W*NREQ-1:0] req_addr;
    logic [DW*NREQ-1:0]      req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    clr_start;
    logic                    clr_busy;
    logic [DW-1:0]           rf_data;
    logic                    rf_load0;
    logic                    rf_load1;
    logic                    rf_load2;
    logic                    rf_load3;

    modport master (
        output req_valid, req_addr, req_data, clr_start,
        input  req_ready, clr_busy, rf_data, rf_load0, rf_load1, rf_load2, rf_load3
    );

    modport slave (
        input  req_valid, req_addr, req_data, clr_start,
        output req_ready, clr_busy, rf_data, rf_load0, rf_load1, rf_load2, rf_load3
    );

endinterface

`default_nettype wire

// File: rtl/regfile_write_ctrl_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick, search starts after last_grant
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]     req,
    input  wire logic [IDX_W-1:0] last_grant,
    input  wire logic             enable,
    output logic      [N-1:0]     grant,
    output logic      [IDX_W-1:0] grant_idx
);

    int   w_idx;
    logic w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int off = 1; off <= N; off++) begin
            // last_grant < N and off <= N, so one subtraction is enough to wrap
            w_idx = int'(last_grant) + off;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (enable && !w_found && req[IDX_W'(w_idx)]) begin
                grant[IDX_W'(w_idx)] = 1'b1;
                grant_idx            = IDX_W'(w_idx);
                w_found              = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_write_ctrl.sv
// ============================================================================
// Module : regfile_write_ctrl
// Brief  : Arbitrates requesters onto the register-file write port, runs clear
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_write_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = 8
) (
    input wire logic             clk,
    input wire logic             reset_n,
    regfile_write_ctrl_if.slave  bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e               r_state;
    logic [RADDR_W-1:0]   r_cnt;
    logic [IDX_W-1:0]     r_last_grant;
    logic [DW-1:0]        r_data;
    logic [NUM_REGS-1:0]  r_load;

    logic [NREQ-1:0]      w_grant;
    logic [IDX_W-1:0]     w_gidx;
    logic                 w_arb_en;
    logic [RADDR_W-1:0]   w_addr [NREQ];
    logic [DW-1:0]        w_data [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addr[gi] = bus.req_addr[RADDR_W*gi +: RADDR_W];
            assign w_data[gi] = bus.req_data[DW*gi +: DW];
        end
    endgenerate

    // Clear request wins over grants; reset_n gates ready while reset is held
    assign w_arb_en = reset_n && (r_state == S_RUN) && !bus.clr_start;

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (bus.req_valid),
        .last_grant (r_last_grant),
        .enable     (w_arb_en),
        .grant      (w_grant),
        .grant_idx  (w_gidx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_RUN;
            r_cnt        <= '0;
            r_last_grant <= IDX_W'(NREQ - 1);
            r_data       <= '0;
            r_load       <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.clr_start) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                        r_load  <= '0;
                    end else if (|w_grant) begin
                        r_last_grant <= w_gidx;
                        r_data       <= w_data[w_gidx];
                        r_load       <= onehot4(w_addr[w_gidx]);
                    end else begin
                        r_load <= '0;
                    end
                end
                S_CLEAR: begin
                    r_data <= '0;
                    r_load <= onehot4(r_cnt);
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == RADDR_W'(NUM_REGS - 1)) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_load  <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.clr_busy  = (r_state == S_CLEAR);
    assign bus.rf_data   = r_data;
    assign bus.rf_load0  = r_load[0];
    assign bus.rf_load1  = r_load[1];
    assign bus.rf_load2  = r_load[2];
    assign bus.rf_load3  = r_load[3];

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_ctrl.sv
// ============================================================================
// Module : tb_regfile_write_ctrl
// Brief  : Directed vector table, clear/reset sequences and random scoreboard
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_ctrl;

    localparam int NREQ = 3;
    localparam int DW   = 8;

    logic clk;
    logic reset_n;

    regfile_write_ctrl_if #(.NREQ(NREQ), .DW(DW)) bus ();

    regfile_write_ctrl #(.NREQ(NREQ), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] w_load;
    assign w_load = {bus.rf_load3, bus.rf_load2, bus.rf_load1, bus.rf_load0};

    logic [DW-1:0] rf_model [4];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_load[i]) rf_model[i] <= bus.rf_data;
        end
    end

    typedef struct {
        logic [2:0]  valid;
        logic [5:0]  addr;
        logic [23:0] data;
        logic        clr;
        logic [2:0]  exp_ready;
        logic [3:0]  exp_load;
        logic [7:0]  exp_data;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [19];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    localparam logic [5:0]  A0 = {2'd3, 2'd1, 2'd2};
    localparam logic [23:0] D0 = 24'hC3_B1_A5;
    localparam logic [5:0]  A1 = {2'd3, 2'd1, 2'd0};
    localparam logic [23:0] D1 = 24'hC3_B1_3C;

    initial begin
        logic       xfer;
        logic [3:0] e_load;
        logic [7:0] e_data;

        //           valid   addr data clr  ready   load     data   busy
        vecs[0]  = '{3'b001, A0, D0, 1'b0, 3'b001, 4'b0100, 8'hA5, 1'b0};
        vecs[1]  = '{3'b111, A0, D0, 1'b0, 3'b010, 4'b0010, 8'hB1, 1'b0};
        vecs[2]  = '{3'b111, A0, D0, 1'b0, 3'b100, 4'b1000, 8'hC3, 1'b0};
        vecs[3]  = '{3'b111, A0, D0, 1'b0, 3'b001, 4'b0100, 8'hA5, 1'b0};
        vecs[4]  = '{3'b111, A0, D0, 1'b0, 3'b010, 4'b0010, 8'hB1, 1'b0};
        vecs[5]  = '{3'b111, A0, D0, 1'b0, 3'b100, 4'b1000, 8'hC3, 1'b0};
        vecs[6]  = '{3'b111, A0, D0, 1'b0, 3'b001, 4'b0100, 8'hA5, 1'b0};
        vecs[7]  = '{3'b111, A0, D0, 1'b0, 3'b010, 4'b0010, 8'hB1, 1'b0};
        vecs[8]  = '{3'b101, A0, D0, 1'b0, 3'b100, 4'b1000, 8'hC3, 1'b0};
        vecs[9]  = '{3'b000, A0, D0, 1'b0, 3'b000, 4'b0000, 8'hC3, 1'b0};
        vecs[10] = '{3'b001, A1, D1, 1'b0, 3'b001, 4'b0001, 8'h3C, 1'b0};
        vecs[11] = '{3'b001, A1, D1, 1'b0, 3'b001, 4'b0001, 8'h3C, 1'b0};
        // clear sweep with req1 pending and a second clr_start mid-sweep
        vecs[12] = '{3'b010, A0, D0, 1'b1, 3'b000, 4'b0000, 8'h3C, 1'b1};
        vecs[13] = '{3'b010, A0, D0, 1'b0, 3'b000, 4'b0001, 8'h00, 1'b1};
        vecs[14] = '{3'b010, A0, D0, 1'b1, 3'b000, 4'b0010, 8'h00, 1'b1};
        vecs[15] = '{3'b010, A0, D0, 1'b0, 3'b000, 4'b0100, 8'h00, 1'b1};
        vecs[16] = '{3'b010, A0, D0, 1'b0, 3'b000, 4'b1000, 8'h00, 1'b0};
        vecs[17] = '{3'b010, A0, D0, 1'b0, 3'b010, 4'b0010, 8'hB1, 1'b0};
        vecs[18] = '{3'b000, A0, D0, 1'b0, 3'b000, 4'b0000, 8'hB1, 1'b0};

        // reset held with all requesters valid
        reset_n       = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_addr  = A0;
        bus.req_data  = D0;
        bus.clr_start = 1'b0;
        #12;
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_load",  32'(w_load),        32'h0);
        chk("rst_data",  32'(bus.rf_data),   32'h0);
        chk("rst_busy",  32'(bus.clr_busy),  32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 19; v++) begin
            @(negedge clk);
            bus.req_valid = vecs[v].valid;
            bus.req_addr  = vecs[v].addr;
            bus.req_data  = vecs[v].data;
            bus.clr_start = vecs[v].clr;
            #1;
            chk($sformatf("v%0d_ready", v), 32'(bus.req_ready), 32'(vecs[v].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_load", v), 32'(w_load),       32'(vecs[v].exp_load));
            chk($sformatf("v%0d_data", v), 32'(bus.rf_data),  32'(vecs[v].exp_data));
            chk($sformatf("v%0d_busy", v), 32'(bus.clr_busy), 32'(vecs[v].exp_busy));
        end
        chk("reg1_after_clear", 32'(rf_model[1]), 32'hB1);
        chk("reg2_after_clear", 32'(rf_model[2]), 32'h00);

        // reset asserted mid-sweep after load1 has been issued
        @(negedge clk);
        bus.req_valid = 3'b000;
        bus.clr_start = 1'b1;
        @(posedge clk); #1;
        chk("ms_busy", 32'(bus.clr_busy), 32'h1);
        @(negedge clk);
        bus.clr_start = 1'b0;
        @(posedge clk); #1;
        chk("ms_load0", 32'(w_load), 32'h1);
        @(posedge clk); #1;
        chk("ms_load1", 32'(w_load), 32'h2);
        reset_n       = 1'b0;
        bus.req_valid = 3'b111;
        #1;
        chk("ms_rst_load",  32'(w_load),        32'h0);
        chk("ms_rst_data",  32'(bus.rf_data),   32'h0);
        chk("ms_rst_busy",  32'(bus.clr_busy),  32'h0);
        chk("ms_rst_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("ms_first_grant", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 3'b000;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("ms_noload%0d", c), 32'(w_load),       32'h0);
            chk($sformatf("ms_nobusy%0d", c), 32'(bus.clr_busy), 32'h0);
        end

        // random traffic with scoreboard on every transfer
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            bus.req_valid = 3'($urandom);
            bus.req_addr  = 6'($urandom);
            bus.req_data  = 24'($urandom);
            bus.clr_start = ($urandom_range(0, 63) == 0);
            #1;
            chk("rnd_ready_onehot", 32'($onehot0(bus.req_ready)), 32'h1);
            xfer   = |(bus.req_valid & bus.req_ready);
            e_load = '0;
            e_data = '0;
            for (int g = 0; g < NREQ; g++) begin
                if (bus.req_valid[g] && bus.req_ready[g]) begin
                    e_load = 4'b0001 << bus.req_addr[2*g +: 2];
                    e_data = bus.req_data[8*g +: 8];
                end
            end
            @(posedge clk); #1;
            chk("rnd_load_onehot", 32'($onehot0(w_load)), 32'h1);
            if (xfer) begin
                chk("rnd_xfer_load", 32'(w_load),      32'(e_load));
                chk("rnd_xfer_data", 32'(bus.rf_data), 32'(e_data));
            end else if (w_load != 4'b0000) begin
                chk("rnd_clear_data", 32'(bus.rf_data), 32'h0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the 4-entry, 8-bit general register file. It arbitrates up to NREQ requesters, each offering (address, data), onto the register file's single shared input bus and its load0..load3 strobes. It also runs a hardware clear sweep that zeroes all four registers. It sits directly in front of the register file and guarantees at most one load strobe per cycle, so the register file's load priority never drops a write.

## Interface
- NREQ, 3, number of write requesters (2..4)
- DW, 8, data width; matches register file width
- clk  in  1  single clock; all state updates on posedge clk
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  2*NREQ  target register for requester i, bits [2i+1:2i]
- req_data  in  DW*NREQ  write data for requester i, bits [DW*i+DW-1:DW*i]
- req_ready  out  NREQ  one-hot or zero; requester i granted this cycle
- clr_start  in  1  pulse; request clear sweep of all registers
- clr_busy  out  1  clear sweep in progress
- rf_data  out  DW  drives register file `in`
- rf_load0..rf_load3  out  1 each  drive register file load0..load3; at most one high

## Operation
- States: S_RUN and S_CLEAR. Reset state is S_RUN.
- S_RUN arbitration:
  - Round-robin over req_valid. Search starts at last_grant+1 and wraps modulo NREQ.
  - last_grant resets to NREQ-1, so requester 0 wins first.
- req_ready:
  - Combinational. In S_RUN, req_ready[g]=1 only for the winner g; 0 if no valid.
  - Transfer occurs when req_valid[i] & req_ready[i].
  - On transfer, last_grant <= g; rf_data <= req_data[g]; rf_load[req_addr[g]] <= 1.
- Cycles with no transfer: all rf_load* <= 0. rf_data holds its last value.
- Requester obligation: once valid, it holds addr/data stable until ready. The controller does not rely on this; it samples only on transfer.
- clr_start in S_RUN:
  - Enter S_CLEAR with cnt <= 0.
  - Clear takes priority: all req_ready=0 that cycle, no transfer, pointer unchanged.
- S_CLEAR:
  - req_ready=0 throughout.
  - Each cycle: rf_data <= 0, rf_load[cnt] <= 1, cnt <= cnt+1.
  - After issuing load3 (cnt==3), return to S_RUN.
  - clr_start is ignored in S_CLEAR (no restart, no queue).
- clr_busy = (state == S_CLEAR).
- Asynchronous reset_n low at any time, including mid-sweep or mid-transfer:
  - state=S_RUN, cnt=0, last_grant=NREQ-1.
  - rf_data=0, all rf_load*=0, clr_busy=0, req_ready=0 while asserted.
  - No partial write is issued after release.

## Timing
- Reset values: rf_data=0, rf_load0..3=0, clr_busy=0, req_ready=0.
- Write latency: transfer at edge k -> rf_load/rf_data valid in cycle after edge k -> register file captures at edge k+1.
- Throughput: one transfer per cycle. Back-to-back grants are allowed, including the same requester if it is the only one valid.
- Clear sweep:
  - clr_start sampled at edge k: clr_busy high after k.
  - rf_load0..3 high in the cycles after edges k+1..k+4 respectively.
  - clr_busy drops after edge k+4. First new grant is possible in that cycle.
- Same register written by a grant and by the sweep: impossible, because grants are blocked during S_CLEAR.

## Structure
- Package regfile_ctrl_pkg holds:
  - state enum {S_RUN, S_CLEAR}
  - NUM_REGS=4 and RADDR_W=2
  - helper function onehot4(addr) -> 4-bit load vector
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], last_grant, enable
  - outputs: grant[N] (one-hot), grant_idx
  - Purely combinational; last_grant register stays in the top level.
- Top level holds the FSM, cnt, last_grant and the output registers.

## Test plan
- Reset: hold reset_n=0 with req_valid=3'b111 -> req_ready=0, rf_load*=0, rf_data=0, clr_busy=0. Release -> requester 0 granted first.
- Single write: req0 valid, addr=2, data=8'hA5 -> req_ready[0] that cycle; next cycle rf_load2=1, rf_data=A5, others 0; register 2 reads A5.
- Round-robin fairness:
  - All three requesters valid for 6 cycles -> grant order 0,1,2,0,1,2.
  - After grant 1, only req0 and req2 valid -> grant 2 next.
- Clear with contention:
  - clr_start with req1 valid -> no ready that cycle.
  - 4 cycles of loads 0,1,2,3 with data 0, clr_busy high for 4 cycles.
  - req1 granted on the cycle clr_busy falls.
  - Second clr_start mid-sweep has no effect.
- Reset mid-sweep: reset_n low after load1 issued -> outputs zero immediately. After release, state S_RUN and no further sweep loads appear.
- One-hot assertion: random valid/addr/clr_start for 10k cycles -> $onehot0 holds on {rf_load3..0} and on req_ready every cycle; every accepted (addr,data) appears exactly once on the rf outputs.
